wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
// - Final (write-back) pipeline stage after the memory stage: commits the retiring instruction to the regfile, HI/LO and CP0.
// - Detects exceptions, interrupts and ERET at commit; redirects fetch and flushes younger stages via a one-cycle cancel.
// - Owns CP0 Status/Cause/EPC/BadVAddr and HI/LO, exporting them for MFHI/MFLO/MFC0 in the memory stage.
// PARAMETERS
// - EXC_VECTOR  32'hBFC0_0380  fetch target on any exception/interrupt
// - STATUS_RST  32'h0040_0000  Status reset value (BEV=1, IE=0, EXL=0)
// PORTS
// - clk          in   1   clock
// - reset        in   1   async active-high reset
// - WB_valid     in   1   instruction present in WB this cycle
// - wb_wen       in   1   instruction writes GPR
// - wb_wdest     in   5   GPR destination
// - wb_wbytes    in   4   GPR byte-lane mask (LWL/LWR partial writes)
// - wb_result    in   32  GPR data / HI data / mtc0 data
// - wb_lo_result in   32  LO data
// - wb_hi_write, wb_lo_write  in  1  HI/LO write request
// - wb_mtc0      in   1   write CP0 reg wb_cp0r_addr ({rd,sel}, 8b) with wb_result
// - wb_cp0r_addr in   8   CP0 address
// - wb_syscall, wb_break, wb_ov_ex, wb_ri_ex, wb_adel_ex, wb_ades_ex, wb_eret  in 1  exception/ERET flags
// - wb_badaddr   in   32  data address (BadVAddr source)
// - wb_pc        in   32  instruction PC
// - wb_jbr       in   1   instruction is branch/jump (next one is a delay slot)
// - hw_int       in   6   external interrupt lines, level sensitive
// - rf_wen       out  4   regfile byte write enables
// - rf_wdest     out  5 ; rf_wdata out 32   regfile write address/data
// - WB_wdest     out  5   dest for hazard check, 0 when !WB_valid
// - WB_over      out  1   = WB_valid (single-cycle stage)
// - cancel       out  1   flush IF..MEM this cycle
// - exc_pc_valid out  1 ; exc_pc out 32   fetch redirect, coincident with cancel
// - HI_data, LO_data, cp0r_status, cp0r_cause, cp0r_epc, cp0r_badvaddr  out 32  architectural state
// BEHAVIOUR
// - Reset: HI=LO=EPC=BadVAddr=Cause=0, Status=STATUS_RST, last_jbr=0; all combinational outputs 0 when !WB_valid.
// - Priority when WB_valid: interrupt > AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdES(5) > ERET; exc = any but ERET.
// - Interrupt pending: Status.IE & !Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]); ExcCode 0.
// - exc: EXL<=1; Cause.ExcCode<=code; BD<=last_jbr; EPC<= last_jbr ? wb_pc-4 : wb_pc; BadVAddr<=wb_badaddr iff AdEL/AdES;
//   rf_wen=0, HI/LO/CP0 writes suppressed; cancel=1, exc_pc=EXC_VECTOR. If EXL=1 already, EPC/BD unchanged.
// - ERET (no exc): EXL<=0; cancel=1, exc_pc=EPC (current register value, not mtc0 same cycle).
// - Normal: rf_wen={4{wb_wen}}&wb_wbytes; rf_wdata=wb_result; HI<=wb_result / LO<=wb_lo_result next edge.
// - mtc0: writable Status.IM[15:8],EXL[1],IE[0]; Cause.IP[9:8]; EPC full; other regs/bits ignored; visible next cycle.
// - Cause.IP[7:2] <= hw_int every cycle regardless of WB_valid; IP7 also ORed with Cause.TI when timer present.
// - last_jbr <= wb_jbr on every WB_valid & !cancel; cleared on cancel.
// - Every exported register reflects state after the last edge (no same-cycle bypass; memory stage forwards HI/LO itself).
// - Reset mid-operation: all state returns to reset values asynchronously; no pending redirect survives.
// CONFIGURATION
// - CP0_TIMER_EN defined: adds Count(9,0)/Compare(11,0) regs, outputs cp0r_count/cp0r_compare 32b; Count increments
//   every 2nd clk (internal toggle, reset 0); Count==Compare (Compare!=0) sets Cause.TI(bit30); mtc0 Compare clears TI;
//   mtc0 Count overrides increment that cycle. Undefined: no such regs/ports, TI always 0, IP7 = hw_int[5].
// TESTING
// - add r3 commit, wb_wbytes=4'b1111, wb_result=32'h1234 -> rf_wen=4'hF, rf_wdest=3, rf_wdata=32'h1234, cancel=0.
// - syscall at pc 0xBFC0_0100, last inst jbr -> cancel=1, exc_pc=0xBFC0_0380, EPC=0xBFC0_00FC, BD=1, ExcCode=8, rf_wen=0.
// - lw AdEL badaddr 0x8000_0003 with wb_mtc0 -> BadVAddr=0x8000_0003, ExcCode=4, no CP0 mtc0 effect, EXL=1.
// - Status=0x0000_0401, hw_int[0]=1 with add in WB -> interrupt, ExcCode=0, EPC=wb_pc, add not committed.
// - EPC=0xBFC0_0200, EXL=1, eret -> cancel=1, exc_pc=0xBFC0_0200, EXL=0 next cycle.
// - CP0_TIMER_EN: mtc0 Compare=10 at Count=0 -> TI=1 after ~20 clks; mtc0 Compare clears TI.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR/HI/LO/CP0 state, resolves exceptions, interrupts and ERET.
// Define CP0_TIMER_EN to add the CP0 Count/Compare timer and its TI interrupt source.
module wb_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WB_valid,
  input  logic        wb_wen,
  input  logic [4:0]  wb_wdest,
  input  logic [3:0]  wb_wbytes,
  input  logic [31:0] wb_result,
  input  logic [31:0] wb_lo_result,
  input  logic        wb_hi_write,
  input  logic        wb_lo_write,
  input  logic        wb_mtc0,
  input  logic [7:0]  wb_cp0r_addr,
  input  logic        wb_syscall,
  input  logic        wb_break,
  input  logic        wb_ov_ex,
  input  logic        wb_ri_ex,
  input  logic        wb_adel_ex,
  input  logic        wb_ades_ex,
  input  logic        wb_eret,
  input  logic [31:0] wb_badaddr,
  input  logic [31:0] wb_pc,
  input  logic        wb_jbr,
  input  logic [5:0]  hw_int,
  output logic [3:0]  rf_wen,
  output logic [4:0]  rf_wdest,
  output logic [31:0] rf_wdata,
  output logic [4:0]  WB_wdest,
  output logic        WB_over,
  output logic        cancel,
  output logic        exc_pc_valid,
  output logic [31:0] exc_pc,
  output logic [31:0] HI_data,
  output logic [31:0] LO_data,
`ifdef CP0_TIMER_EN
  output logic [31:0] cp0r_count,
  output logic [31:0] cp0r_compare,
`endif
  output logic [31:0] cp0r_status,
  output logic [31:0] cp0r_cause,
  output logic [31:0] cp0r_epc,
  output logic [31:0] cp0r_badvaddr
);

  // CP0 addresses are {rd, sel}
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;
`ifdef CP0_TIMER_EN
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
`endif

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        last_jbr_q, last_jbr_d;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q;
`endif

  logic        status_ie, status_exl;
  logic        int_pending;
  logic        exc;
  logic        exc_addr;
  logic [4:0]  exc_code;
  logic        eret_take;
  logic        commit;
  logic        cp0_wr;

  assign status_ie   = status_q[0];
  assign status_exl  = status_q[1];
  assign int_pending = status_ie & ~status_exl & (|(cause_q[15:8] & status_q[15:8]));

  // Exception selection in architectural priority order
  always_comb begin
    exc      = 1'b0;
    exc_addr = 1'b0;
    exc_code = EXC_INT;
    if (WB_valid) begin
      if (int_pending) begin
        exc      = 1'b1;
        exc_code = EXC_INT;
      end else if (wb_adel_ex) begin
        exc      = 1'b1;
        exc_addr = 1'b1;
        exc_code = EXC_ADEL;
      end else if (wb_ri_ex) begin
        exc      = 1'b1;
        exc_code = EXC_RI;
      end else if (wb_ov_ex) begin
        exc      = 1'b1;
        exc_code = EXC_OV;
      end else if (wb_syscall) begin
        exc      = 1'b1;
        exc_code = EXC_SYS;
      end else if (wb_break) begin
        exc      = 1'b1;
        exc_code = EXC_BP;
      end else if (wb_ades_ex) begin
        exc      = 1'b1;
        exc_addr = 1'b1;
        exc_code = EXC_ADES;
      end
    end
  end

  assign eret_take = WB_valid & wb_eret & ~exc;
  assign commit    = WB_valid & ~exc;
  assign cp0_wr    = commit & wb_mtc0;

  always_comb begin
    rf_wen       = commit ? ({4{wb_wen}} & wb_wbytes) : 4'h0;
    rf_wdest     = WB_valid ? wb_wdest : 5'd0;
    rf_wdata     = WB_valid ? wb_result : 32'h0;
    WB_wdest     = WB_valid ? wb_wdest : 5'd0;
    WB_over      = WB_valid;
    cancel       = exc | eret_take;
    exc_pc_valid = exc | eret_take;
    // ERET returns to the EPC held before this edge, ignoring a coincident mtc0
    if (exc) begin
      exc_pc = EXC_VECTOR;
    end else if (eret_take) begin
      exc_pc = epc_q;
    end else begin
      exc_pc = 32'h0;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && wb_hi_write) begin
      hi_d = wb_result;
    end
    if (commit && wb_lo_write) begin
      lo_d = wb_lo_result;
    end
  end

  always_comb begin
    status_d = status_q;
    if (cp0_wr && wb_cp0r_addr == CP0_STATUS) begin
      status_d[15:8] = wb_result[15:8];
      status_d[1:0]  = wb_result[1:0];
    end
    if (exc) begin
      status_d[1] = 1'b1;
    end else if (eret_take) begin
      status_d[1] = 1'b0;
    end
  end

  always_comb begin
    cause_d = cause_q;
    // IP7..IP2 sample the external lines every cycle
`ifdef CP0_TIMER_EN
    cause_d[15:10] = {hw_int[5] | cause_q[30], hw_int[4:0]};
`else
    cause_d[15:10] = hw_int;
`endif
    if (cp0_wr && wb_cp0r_addr == CP0_CAUSE) begin
      cause_d[9:8] = wb_result[9:8];
    end
`ifdef CP0_TIMER_EN
    if (cp0_wr && wb_cp0r_addr == CP0_COMPARE) begin
      cause_d[30] = 1'b0;
    end else if (count_q == compare_q && compare_q != 32'h0) begin
      cause_d[30] = 1'b1;
    end
`endif
    if (exc) begin
      cause_d[6:2] = exc_code;
      if (!status_exl) begin
        cause_d[31] = last_jbr_q;
      end
    end
  end

  always_comb begin
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (cp0_wr && wb_cp0r_addr == CP0_EPC) begin
      epc_d = wb_result;
    end
    // Nested exceptions keep the original return point
    if (exc && !status_exl) begin
      epc_d = last_jbr_q ? (wb_pc - 32'd4) : wb_pc;
    end
    if (exc && exc_addr) begin
      badvaddr_d = wb_badaddr;
    end
  end

  always_comb begin
    last_jbr_d = last_jbr_q;
    if (cancel) begin
      last_jbr_d = 1'b0;
    end else if (WB_valid) begin
      last_jbr_d = wb_jbr;
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d   = tick_q ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    if (cp0_wr && wb_cp0r_addr == CP0_COUNT) begin
      count_d = wb_result;
    end
    if (cp0_wr && wb_cp0r_addr == CP0_COMPARE) begin
      compare_d = wb_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
    end else begin
      tick_q    <= ~tick_q;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign cp0r_count   = count_q;
  assign cp0r_compare = compare_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      last_jbr_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      last_jbr_q <= last_jbr_d;
    end
  end

  assign HI_data       = hi_q;
  assign LO_data       = lo_q;
  assign cp0r_status   = status_q;
  assign cp0r_cause    = cause_q;
  assign cp0r_epc      = epc_q;
  assign cp0r_badvaddr = badvaddr_q;

  // BadVAddr is read-only to software; the address is decoded only to document that
  logic unused_badvaddr_wr;
  assign unused_badvaddr_wr = cp0_wr & (wb_cp0r_addr == CP0_BADVADDR);

endmodule
